// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data (LW/SW) requests.
// Latency: grant edge -> BUSY until mem_ack -> one RESP cycle with valid pulse (>= 3 cycles per access).
// Backpressure: requesters hold req until their valid pulse (stall covers that window); mem_ack paces BUSY, TIMEOUT bounds it.
// Ports: clk/reset; halt from decode; if_* fetch port; d_* data port; mem_* memory command/response;
//        stall (combinational pipeline freeze); err (one-cycle timeout pulse).
module mem_arbiter #(
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, IF_BUSY, D_BUSY, RESP, HALTED} state_t;

  state_t          state, state_nxt;
  logic [1:0]      starve;
  logic [TW-1:0]   tcount;
  logic            halt_seen;   // halt arrived while an access was in flight
  logic            grant_if, grant_d, busy, ack_take, timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    busy        = (state == IF_BUSY) || (state == D_BUSY);
    case (state)
      IDLE: begin
        if (halt || halt_seen) begin
          state_nxt = HALTED;
        end else if (d_req && !(if_req && starve == 2'd3)) begin
          // data normally wins; a saturated starve count hands the slot to fetch
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ack) begin
          ack_take  = 1'b1;
          state_nxt = RESP;
        end else if (tcount == TW'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th BUSY cycle without an ack
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      RESP:    state_nxt = IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      starve    <= '0;
      tcount    <= '0;
      halt_seen <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      if (halt) halt_seen <= 1'b1;

      if (grant_d) begin
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        tcount    <= '0;
        if (if_req && starve != 2'd3) starve <= starve + 2'd1;
      end else if (grant_if) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= 4'hF;
        tcount    <= '0;
        starve    <= '0;
      end

      if (ack_take) begin
        mem_en <= 1'b0;
        if (state == D_BUSY) begin
          d_valid <= 1'b1;
          // a store completes without touching the load data register
          if (!mem_we) d_rdata <= mem_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end else if (timeout_hit) begin
        mem_en <= 1'b0;
        err    <= 1'b1;
      end else if (busy) begin
        tcount <= tcount + TW'(1);
      end
    end
  end

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule
